// File: rtl/seg_scan_display.sv
// ---------------------------------------------------------------------------
// seg_scan_display
//
// Eight-digit multiplexed seven-segment driver. A 33-bit word (32-bit value
// in data[32:1], valid flag in data[0]) is captured once per frame and
// scanned out one hex digit at a time. Capturing only at the frame boundary
// guarantees that a displayed frame never mixes old and new values.
//
// Parameters
//   SCAN_DIV  clock cycles each digit is held (legal range 2 .. 2^24)
//
// Ports
//   clk    in   1   board clock, all state on the rising edge
//   Rst    in   1   asynchronous active-low reset
//   data   in   33  data[32:1] value to show, data[0] valid (0 -> dashes)
//   which  out  3   selected digit, 0 = rightmost / least significant
//   seg    out  8   active-high segments, seg[0]=a .. seg[6]=g, seg[7]=dp
//
// Build option
//   SEG_LZ_BLANK_EN  when defined, leading zeros of a valid snapshot are
//                    blanked (digit 0 is never blanked). When undefined,
//                    all eight digits are always decoded.
// ---------------------------------------------------------------------------
module seg_scan_display #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [32:0] data,
  output logic [2:0]  which,
  output logic [7:0]  seg
);

  // Prescaler width: enough bits to hold SCAN_DIV-1.
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [2:0] LAST_DIGIT = 3'd7;
  localparam logic [7:0] SEG_BLANK  = 8'h00;
  localparam logic [7:0] SEG_DASH   = 8'h40;

  // -------------------------------------------------------------------------
  // Hex nibble to segment pattern (a..g in bits 0..6, dp always off).
  // -------------------------------------------------------------------------
  function automatic logic [7:0] hex_decode(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0:    pat = 8'h3F;
      4'h1:    pat = 8'h06;
      4'h2:    pat = 8'h5B;
      4'h3:    pat = 8'h4F;
      4'h4:    pat = 8'h66;
      4'h5:    pat = 8'h6D;
      4'h6:    pat = 8'h7D;
      4'h7:    pat = 8'h07;
      4'h8:    pat = 8'h7F;
      4'h9:    pat = 8'h6F;
      4'hA:    pat = 8'h77;
      4'hB:    pat = 8'h7C;
      4'hC:    pat = 8'h39;
      4'hD:    pat = 8'h5E;
      4'hE:    pat = 8'h79;
      4'hF:    pat = 8'h71;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // -------------------------------------------------------------------------
  // Select nibble idx of a 32-bit value (digit k uses bits 4k+3..4k).
  // -------------------------------------------------------------------------
  function automatic logic [3:0] nibble_at(input logic [31:0] val,
                                           input logic [2:0]  idx);
    logic [3:0] nib;
    case (idx)
      3'd0:    nib = val[3:0];
      3'd1:    nib = val[7:4];
      3'd2:    nib = val[11:8];
      3'd3:    nib = val[15:12];
      3'd4:    nib = val[19:16];
      3'd5:    nib = val[23:20];
      3'd6:    nib = val[27:24];
      3'd7:    nib = val[31:28];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  // -------------------------------------------------------------------------
  // Full pattern for digit idx of a 33-bit snapshot (value + valid flag).
  // Invalid snapshots always give a dash, whatever the build option.
  // -------------------------------------------------------------------------
  function automatic logic [7:0] digit_pattern(input logic [32:0] snap,
                                               input logic [2:0]  idx);
    logic [7:0]  pat;
    logic [31:0] val;
`ifdef SEG_LZ_BLANK_EN
    logic [31:0] upper;
`endif
    val = snap[32:1];
    if (snap[0] == 1'b0) begin
      pat = SEG_DASH;
    end else begin
      pat = hex_decode(nibble_at(val, idx));
`ifdef SEG_LZ_BLANK_EN
      // A digit is a leading zero when it and every digit above it are zero.
      // Digit 0 is exempt so that a value of zero still shows one "0".
      upper = val >> {idx, 2'b00};
      if ((idx != 3'd0) && (upper == 32'd0)) begin
        pat = SEG_BLANK;
      end else begin
        pat = pat;
      end
`endif
    end
    return pat;
  endfunction

  // State
  logic [DIV_W-1:0] div_cnt_r;
  logic [2:0]       which_r;
  logic [7:0]       seg_r;
  logic [32:0]      shadow_r;

  // Next-step values
  logic             tick_s;
  logic             frame_end_s;
  logic [2:0]       next_which_s;
  logic [32:0]      decode_src_s;
  logic [7:0]       next_seg_s;

  // Tick and next-digit computation; on the frame-closing tick the decode
  // reads the incoming word so digit 0 already matches the new snapshot.
  always_comb begin
    tick_s       = (div_cnt_r == DIV_LAST);
    frame_end_s  = (which_r == LAST_DIGIT);
    next_which_s = 3'd0;
    decode_src_s = shadow_r;
    if (frame_end_s) begin
      next_which_s = 3'd0;
      decode_src_s = data;
    end else begin
      next_which_s = which_r + 3'd1;
      decode_src_s = shadow_r;
    end
    next_seg_s = digit_pattern(decode_src_s, next_which_s);
  end

  // Prescaler: counts 0..SCAN_DIV-1 and wraps, one tick per digit dwell.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      div_cnt_r <= DIV_ZERO;
    end else if (tick_s) begin
      div_cnt_r <= DIV_ZERO;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  // Digit scan and frame snapshot; which and seg always update together.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      which_r  <= 3'd0;
      seg_r    <= SEG_BLANK;
      shadow_r <= 33'd0;
    end else if (tick_s) begin
      which_r <= next_which_s;
      seg_r   <= next_seg_s;
      if (frame_end_s) begin
        shadow_r <= data;
      end else begin
        shadow_r <= shadow_r;
      end
    end else begin
      which_r  <= which_r;
      seg_r    <= seg_r;
      shadow_r <= shadow_r;
    end
  end

  assign which = which_r;
  assign seg   = seg_r;

endmodule

// File: tb/tb_seg_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_display
//
// Bench for seg_scan_display with SCAN_DIV = 4 (frame = 32 cycles). The
// reference model works from the number of clock edges since reset release:
// tick k happens on edge 4k, which = k mod 8, and a new snapshot is taken on
// every edge that is a multiple of 32. Directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_seg_scan_display;

  localparam int DIV = 4;
  localparam logic [7:0] HEX [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F,
                                      8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h77, 8'h7C,
                                      8'h39, 8'h5E, 8'h79, 8'h71};

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic [32:0] data = 33'd0;
  logic [2:0]  which;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          model_edges = 0;
  logic [32:0] model_snap = 33'd0;

  seg_scan_display #(.SCAN_DIV(DIV)) dut (
    .clk   (clk),
    .Rst   (Rst),
    .data  (data),
    .which (which),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  // Model: count edges since reset release, capture data every 32 edges.
  always @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      model_edges <= 0;
      model_snap  <= 33'd0;
    end else begin
      model_edges <= model_edges + 1;
      if (((model_edges + 1) % (8 * DIV)) == 0) model_snap <= data;
    end
  end

  function automatic logic [2:0] model_which(input int n);
    int k;
    k = (n / DIV) % 8;
    return k[2:0];
  endfunction

  function automatic logic [7:0] model_seg(input int n, input logic [32:0] snap);
    int k;
    int d;
    logic [31:0] up;
    k = n / DIV;
    if (k == 0) return 8'h00;
    d = k % 8;
    if (snap[0] == 1'b0) return 8'h40;
    up = snap[32:1] >> (4 * d);
`ifdef SEG_LZ_BLANK_EN
    if (d != 0 && up == 32'd0) return 8'h00;
`endif
    return HEX[up[3:0]];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance to the next negedge where the edge count sits at frame position p.
  task automatic goto_pos(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((model_edges % (8 * DIV)) != p && n < 100);
    if (n >= 100) chk("goto_pos_timeout", 32'd1, 32'd0);
  endtask

  // Advance to the next snapshot edge.
  task automatic goto_snap();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(model_edges > 0 && (model_edges % (8 * DIV)) == 0) && n < 100);
    if (n >= 100) chk("goto_snap_timeout", 32'd1, 32'd0);
  endtask

  logic [7:0] exp_a [8];
  logic [7:0] exp_b [8];

  initial begin
    // Reset
    #1 Rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_which", {29'd0, which}, 32'd0);
    chk("reset_seg", {24'd0, seg}, 32'h00);

    // Per-cycle comparison against the model from here on.
    fork
      forever begin
        @(negedge clk);
        chk("scan_which", {29'd0, which}, {29'd0, model_which(model_edges)});
        chk("scan_seg", {24'd0, seg}, {24'd0, model_seg(model_edges, model_snap)});
      end
    join_none

    // First tick after release: dashes because the shadow is still invalid.
    Rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_tick_seg", {24'd0, seg}, 32'h00);
    @(negedge clk);
    chk("first_tick_which", {29'd0, which}, 32'd1);
    chk("first_tick_seg", {24'd0, seg}, 32'h40);

    // Steady frame of 0123ABCD
    data = {32'h0123ABCD, 1'b1};
    exp_a = '{8'h5E, 8'h39, 8'h7C, 8'h77, 8'h4F, 8'h5B, 8'h06, 8'h3F};
    goto_snap();
    for (int d = 0; d < 8; d++) begin
      chk("hex_which", {29'd0, which}, d);
      chk("hex_seg", {24'd0, seg}, {24'd0, exp_a[d]});
      repeat (DIV) @(negedge clk);
    end
    chk("repeat_seg", {24'd0, seg}, 32'h5E);

    // Invalid data shows dashes everywhere
    data = {32'h88888888, 1'b0};
    goto_snap();
    chk("invalid_d0", {24'd0, seg}, 32'h40);
    goto_pos(20);
    chk("invalid_d5", {24'd0, seg}, 32'h40);

    // Switch mid-frame: takes effect only at the next boundary
    data = {32'h11111111, 1'b1};
    goto_snap();
    goto_pos(12);
    chk("switch_which", {29'd0, which}, 32'd3);
    data = {32'h22222222, 1'b1};
    for (int d = 3; d < 8; d++) begin
      chk("switch_old_seg", {24'd0, seg}, 32'h06);
      repeat (DIV) @(negedge clk);
    end
    chk("switch_wrap_which", {29'd0, which}, 32'd0);
    chk("switch_new_seg", {24'd0, seg}, 32'h5B);

    // One-cycle valid pulse off the snapshot tick: ignored
    data = {32'h12345678, 1'b0};
    goto_snap();
    goto_pos(18);
    data[0] = 1'b1;
    @(negedge clk);
    data[0] = 1'b0;
    chk("pulse_seg_a", {24'd0, seg}, 32'h40);
    goto_pos(0);
    chk("pulse_seg_b", {24'd0, seg}, 32'h40);
    goto_pos(4);
    chk("pulse_seg_c", {24'd0, seg}, 32'h40);

    // Leading zeros
`ifdef SEG_LZ_BLANK_EN
    exp_a = '{8'h6D, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_b = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    exp_a = '{8'h6D, 8'h77, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
    exp_b = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
`endif
    data = {32'h000000A5, 1'b1};
    goto_snap();
    for (int d = 0; d < 8; d++) begin
      chk("lz_a5_seg", {24'd0, seg}, {24'd0, exp_a[d]});
      repeat (DIV) @(negedge clk);
    end
    data = {32'h00000000, 1'b1};
    goto_snap();
    for (int d = 0; d < 8; d++) begin
      chk("lz_zero_seg", {24'd0, seg}, {24'd0, exp_b[d]});
      repeat (DIV) @(negedge clk);
    end

    // Reset mid-frame: clears immediately, pending snapshot discarded
    goto_pos(9);
    #2 Rst = 1'b0;
    #1;
    chk("async_rst_which", {29'd0, which}, 32'd0);
    chk("async_rst_seg", {24'd0, seg}, 32'h00);
    repeat (3) @(negedge clk);
    Rst = 1'b1;
    repeat (DIV) @(negedge clk);
    chk("rerun_which", {29'd0, which}, 32'd1);
    chk("rerun_seg", {24'd0, seg}, 32'h40);
    goto_snap();
    chk("rerun_snap_seg", {24'd0, seg}, 32'h3F);
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Eight-digit multiplexed seven-segment driver on the board-level output path, downstream of the CPU debug mux. It consumes a 33-bit word (32-bit value plus a valid flag) and scans it out one hex digit at a time on `which`/`seg`. It snapshots the word once per frame so a digit never shows a mix of old and new values. All outputs are registered.

## Interface
- `SCAN_DIV`, default 100000: clock cycles each digit is held (1 ms at 100 MHz); legal range 2..2^24.
- `clk`  in  1  board clock; all state on the rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `data`  in  33  `data[32:1]` is the value to display; `data[0]` is valid (1 = show hex, 0 = show dashes).
- `which`  out  3  selected digit index; 0 is the rightmost, least significant digit.
- `seg`  out  8  segment pattern, active-high; `seg[0]`=a … `seg[6]`=g, `seg[7]`=dp (always 0).

## Operation
- **Prescaler** `div_cnt` counts 0..SCAN_DIV-1 and wraps. The tick condition is `div_cnt == SCAN_DIV-1`.
- **On each tick:**
  - `which` advances by 1, modulo 8.
  - `seg` is loaded with the decode for the new `which`.
- **Frame snapshot**, on a tick where `which == 7`:
  - `shadow <= data`.
  - `which <= 0`.
  - `seg` is decoded from the incoming `data`, not the stale shadow, so digit 0 of the new frame is already consistent.
  - `data` is ignored at all other times.
- **Nibble select:** digit k shows `shadow[4k+4:4k+1]`.
- **Hex decode:** 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- **Invalid data** (snapshot bit 0 = 0): every digit shows 0x40 (a dash).

## Timing
- **Reset values (asynchronous, immediate):**
  - `which` = 0, `seg` = 0x00 (blank), `div_cnt` = 0, `shadow` = 0.
- **First frame after reset:**
  - First tick occurs SCAN_DIV cycles after reset release: `which`=1, `seg`=0x40, because the shadow is still invalid.
  - Digit 0 of the first partial frame stays blank.
- **Dwell:** exactly SCAN_DIV cycles per digit; frame period is 8·SCAN_DIV cycles.
- **Output alignment:** `which` and `seg` change on the same edge and are never skewed.
- **Latency:**
  - A change on `data` is visible at the next frame boundary.
  - Worst case: 8·SCAN_DIV cycles.
  - Best case: `data` present on the 7→0 tick edge, visible on that same edge.
- **Data held across a boundary:** no visible change, and the pattern repeats identically every frame.
- **Reset mid-frame:** all state clears immediately. Scanning restarts from `which`=0 with a blank `seg`, and the pending snapshot is discarded.
- **`data` changing on a non-snapshot tick:** no effect.
- **Wrap:** `which` goes 7→0 only through the snapshot path; there is no other wrap.

## Configuration
- **Macro:** `SEG_LZ_BLANK_EN`.
- **Defined:** leading-zero blanking applies to valid snapshots.
  - Digits above the most significant nonzero nibble output 0x00.
  - Digit 0 is never blanked, so a value of 0 shows a single "0" (0x3F) on digit 0 and blanks on digits 1–7.
  - Evaluation uses the same snapshot as the decode, so blanking changes only at frame boundaries.
  - Invalid data still shows dashes on all 8 digits.
- **Undefined:** all 8 digits are always decoded, including leading zeros, and no blanking logic is built.

## Test plan
All scenarios use SCAN_DIV=4 (frame = 32 cycles).
1. Assert `Rst`=0 mid-scan → `which`=0 and `seg`=0x00 with no clock edge. Release → after 4 cycles `which`=1, `seg`=0x40.
2. `data`={32'h0123ABCD,1} held → in the steady frame, `which`=0..7 show 5E, 39, 7C, 77, 4F, 5B, 06, 3F, each held 4 cycles.
3. `data`={32'h88888888,0} → all digits show 0x40 every frame.
4. Switch `data` from {32'h11111111,1} to {32'h22222222,1} while `which`=3 →
   - digits 3–7 of the current frame show 06;
   - the next frame shows 5B starting on the 7→0 edge.
5. With `SEG_LZ_BLANK_EN`:
   - `data`={32'h000000A5,1} → digits 0,1 show 6D, 77; digits 2–7 show 00.
   - `data`={32'h0,1} → digit 0 shows 3F; digits 1–7 show 00.
   - Without the macro, the same input shows 3F on digits 2–7.
6. Pulse `data[0]` high for 1 cycle off a snapshot tick → no change on `seg`.
